uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serial UART transmitter: 8N1 framing, LSB first, fixed bit period in clock cycles.
//   Accepts one byte per ok pulse while idle and drives the line until the frame ends.
//   Sits between the core's output byte source and the board TX pin.
//   busy tells the producer when a new byte may be offered.
// PARAMETERS
//   CYCLES_PER_BIT  default 868  clock cycles per UART bit (868 = 115200 baud at 100 MHz); must be >= 2
// PORTS
//   clk      in   1  system clock; all state updates on rising edge
//   reset    in   1  asynchronous, active-low reset (0 = reset)
//   data     in   8  byte to send; sampled only on the accepting edge
//   ok       in   1  send request; level-sensitive, honoured only when idle
//   uart_tx  out  1  serial line; idle/mark = 1
//   busy     out  1  1 from the accepting edge until the stop bit completes
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE, uart_tx=1, busy=0, bit/cycle counters=0.
//     Asserting reset mid-frame aborts the frame immediately; line returns to 1.
//   All outputs are registered. uart_tx and busy are never combinational from ok or data.
//   States: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: uart_tx=1, busy=0. On a rising edge with ok==1:
//     latch data into the shift register; go to START; uart_tx=0, busy=1 from this edge.
//     Latency: one edge from ok to start bit.
//   START: hold uart_tx=0 for CYCLES_PER_BIT cycles, then enter DATA with bit 0.
//   DATA: drive latched bits 0..7 (LSB first), each for exactly CYCLES_PER_BIT cycles.
//   STOP: uart_tx=1 for CYCLES_PER_BIT cycles, busy still 1.
//     On the edge that ends STOP: go to IDLE, busy=0.
//   Frame length: exactly 10*CYCLES_PER_BIT cycles from the accepting edge to busy falling.
//   ok while busy (START/DATA/STOP) is ignored and never queued.
//     A request still high in the first IDLE cycle is accepted then (back-to-back frames).
//   data changes after acceptance do not affect the frame in flight.
//   Cycle counter counts 0..CYCLES_PER_BIT-1 and wraps at each bit boundary.
//     Bit counter 0..7 is used in DATA only.
//   Width: counter width is $clog2(CYCLES_PER_BIT); no other arithmetic.
// TESTING (CYCLES_PER_BIT=8; samples on falling edge)
//   1. Hold reset=0 for 4 cycles -> uart_tx=1, busy=0.
//      Release reset, wait 10 cycles -> uart_tx=1, busy=0.
//   2. data=8'b00110101, ok=1 for one cycle.
//      -> next sample uart_tx=0, busy=1.
//      -> samples every 8 cycles read 1,0,1,0,1,1,0,0 with busy=1.
//   3. Mid-frame, after bit 7: data=0, ok=1.
//      -> 8 cycles later uart_tx=1 (stop bit), busy=1; 4 cycles later still 1/1.
//      The request is not accepted.
//   4. ok=0, wait 8 cycles -> uart_tx=1, busy=0 (frame done, 80 cycles total).
//   5. ok=1 while idle -> next cycle uart_tx=0, busy=1.
//      8 cycles later uart_tx=0 (bit 0 of 8'h00).
//   6. Pull reset=0 mid-DATA -> uart_tx=1, busy=0 immediately without a clock edge.
//      After release the next ok starts a clean frame.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// Byte-in / serial-out signal bundle between a byte producer and the UART transmitter.
// The producer drives data/ok. The transmitter returns uart_tx and busy.
interface uart_transmitter_if;
  logic [7:0] data;
  logic       ok;
  logic       uart_tx;
  logic       busy;

  modport master (
    output data,
    output ok,
    input  uart_tx,
    input  busy
  );

  modport slave (
    input  data,
    input  ok,
    output uart_tx,
    output busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, with a fixed bit period of CYCLES_PER_BIT clocks.
// It accepts one byte per ok while idle. busy covers the whole frame, up to the end of the stop bit.
module uart_transmitter #(
  parameter int CYCLES_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              reset,
  uart_transmitter_if.slave bus
);

  localparam int              CYC_W    = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q,    tx_d;
  logic             busy_q,  busy_d;
  logic             bit_end;

  assign bit_end = (cycle_q == CYC_LAST);

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    if (state_q != S_IDLE) begin
      cycle_d = bit_end ? '0 : cycle_q + CYC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.ok) begin
          state_d = S_START;
          shift_d = bus.data;
          cycle_d = '0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        // The register shifts right. Bit 0 of the register is always the next data bit to drive.
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[7:1]};
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[7:1]};
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cycle_d = '0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.uart_tx = tx_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter with an 8-cycle bit period. Each task drives one scenario.
// A task checks the sampled line against a frame-level model of 8N1 framing.
module tb_uart_transmitter;

  localparam int CPB   = 8;
  localparam int FRAME = 10 * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_transmitter_if bus_if ();

  uart_transmitter #(.CYCLES_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Expected line level k cycles after the accepting edge: start(0), 8 data bits LSB first, then stop(1).
  function automatic logic exp_line(input logic [7:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    bus_if.ok   = 1'b0;
    bus_if.data = 8'h00;
    reset       = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus_if.uart_tx !== 1'b1 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: uart_tx=%b busy=%b, expected 1/0", bus_if.uart_tx, bus_if.busy);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus_if.uart_tx !== 1'b1 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: uart_tx=%b busy=%b, expected 1/0", bus_if.uart_tx, bus_if.busy);
    end
    $display("reset: line idle after release");
  endtask

  // Sends the spec byte. A request raised after bit 7 and dropped during the stop bit must be ignored.
  task automatic test_basic_frame();
    logic [7:0] d;
    logic       exp_tx, exp_busy;
    d           = 8'b0011_0101;
    bus_if.data = d;
    bus_if.ok   = 1'b1;
    for (int k = 0; k < FRAME + 8; k++) begin
      @(negedge clk);
      if (k == 0) bus_if.ok = 1'b0;
      exp_tx   = (k < FRAME) ? exp_line(d, k) : 1'b1;
      exp_busy = (k < FRAME);
      checks++;
      if (bus_if.uart_tx !== exp_tx || bus_if.busy !== exp_busy) begin
        errors++;
        $display("FAIL basic_frame k=%0d: uart_tx=%b busy=%b, expected %b/%b",
                 k, bus_if.uart_tx, bus_if.busy, exp_tx, exp_busy);
      end
      if (k == 8 * CPB) begin
        bus_if.data = 8'h00;
        bus_if.ok   = 1'b1;
      end
      if (k == 9 * CPB + 4) bus_if.ok = 1'b0;
    end
    $display("basic_frame: data=%02h sent, mid-frame request ignored", d);
  endtask

  // Random bytes. ok and data are randomised while busy and must not disturb the frame in flight.
  task automatic test_random_frames();
    logic [7:0] d;
    logic       exp_tx, exp_busy;
    for (int n = 0; n < 6; n++) begin
      d           = 8'($urandom);
      bus_if.data = d;
      bus_if.ok   = 1'b1;
      for (int k = 0; k <= FRAME; k++) begin
        @(negedge clk);
        exp_tx   = (k < FRAME) ? exp_line(d, k) : 1'b1;
        exp_busy = (k < FRAME);
        checks++;
        if (bus_if.uart_tx !== exp_tx || bus_if.busy !== exp_busy) begin
          errors++;
          $display("FAIL random_frame n=%0d k=%0d: uart_tx=%b busy=%b, expected %b/%b",
                   n, k, bus_if.uart_tx, bus_if.busy, exp_tx, exp_busy);
        end
        if (k < FRAME) begin
          bus_if.ok   = 1'($urandom_range(0, 1));
          bus_if.data = 8'($urandom);
        end else begin
          bus_if.ok = 1'b0;
        end
      end
      $display("random_frame %0d: data=%02h", n, d);
    end
    @(negedge clk);
  endtask

  // With ok held high, frames follow with exactly one idle cycle between them.
  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] d;
    logic       exp_tx, exp_busy;
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    bus_if.data = q[0];
    bus_if.ok   = 1'b1;
    while (q.size() > 0) begin
      d = q.pop_front();
      for (int k = 0; k <= FRAME; k++) begin
        @(negedge clk);
        exp_tx   = (k < FRAME) ? exp_line(d, k) : 1'b1;
        exp_busy = (k < FRAME);
        checks++;
        if (bus_if.uart_tx !== exp_tx || bus_if.busy !== exp_busy) begin
          errors++;
          $display("FAIL back_to_back k=%0d: uart_tx=%b busy=%b, expected %b/%b",
                   k, bus_if.uart_tx, bus_if.busy, exp_tx, exp_busy);
        end
        if (k < FRAME) begin
          bus_if.data = 8'($urandom);
        end else if (q.size() > 0) begin
          bus_if.data = q[0];
        end else begin
          bus_if.ok = 1'b0;
        end
      end
      $display("back_to_back: data=%02h", d);
    end
    @(negedge clk);
  endtask

  // Reset asserted mid-DATA must idle the line without a clock edge. The next frame must then be clean.
  task automatic test_async_reset();
    logic [7:0] d;
    logic       exp_tx, exp_busy;
    d           = 8'h00;
    bus_if.data = d;
    bus_if.ok   = 1'b1;
    for (int k = 0; k < 3 * CPB + 3; k++) begin
      @(negedge clk);
      if (k == 0) bus_if.ok = 1'b0;
      exp_tx = exp_line(d, k);
      checks++;
      if (bus_if.uart_tx !== exp_tx || bus_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL pre_reset_frame k=%0d: uart_tx=%b busy=%b, expected %b/1",
                 k, bus_if.uart_tx, bus_if.busy, exp_tx);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus_if.uart_tx !== 1'b1 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: uart_tx=%b busy=%b, expected 1/0", bus_if.uart_tx, bus_if.busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.uart_tx !== 1'b1 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: uart_tx=%b busy=%b, expected 1/0", bus_if.uart_tx, bus_if.busy);
    end
    d           = 8'($urandom);
    bus_if.data = d;
    bus_if.ok   = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 0) bus_if.ok = 1'b0;
      exp_tx   = (k < FRAME) ? exp_line(d, k) : 1'b1;
      exp_busy = (k < FRAME);
      checks++;
      if (bus_if.uart_tx !== exp_tx || bus_if.busy !== exp_busy) begin
        errors++;
        $display("FAIL post_reset_frame k=%0d: uart_tx=%b busy=%b, expected %b/%b",
                 k, bus_if.uart_tx, bus_if.busy, exp_tx, exp_busy);
      end
    end
    $display("async_reset: frame aborted, clean frame data=%02h after release", d);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
